// File: rtl/serial_subtractor_v_if.sv
// Handshake bundle for the bit-serial subtractor: operand-side valid/ready,
// result-side valid/ready and the result fields.
interface serial_subtractor_v_if #(
  parameter int WIDTH = 8
) ();
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;
  logic             o_zero;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_diff, o_borrow, o_zero
  );

  // Subtractor side
  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_diff, o_borrow, o_zero
  );
endinterface

// File: rtl/serial_subtractor_v.sv
// Bit-serial unsigned subtractor: accepts an operand pair in IDLE, processes
// one bit per clock LSB first through a full subtractor, then presents
// difference, borrow and zero flag in DONE until the consumer takes them.
module serial_subtractor_v #(
  parameter int WIDTH = 8
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  serial_subtractor_v_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value seen on the last RUN edge; the counter stops at WIDTH.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // One full-subtractor step: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    full_sub = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
  endfunction

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic             ready_r;
  logic             valid_r;
  logic             zero_r;

  logic [1:0]       fs_s;
  logic [WIDTH-1:0] res_next_s;

  // Current-bit subtraction and the result register after shifting d into the MSB
  always_comb begin
    fs_s                   = full_sub(a_r[0], b_r[0], br_r);
    res_next_s             = res_r >> 1'b1;
    res_next_s[WIDTH-1]    = fs_s[0];
  end

  // Control FSM plus operand, result, borrow and flag registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.i_valid) begin
            a_r     <= bus.i_a;
            b_r     <= bus.i_b;
            br_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b0;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r   <= a_r >> 1'b1;
          b_r   <= b_r >> 1'b1;
          br_r  <= fs_s[1];
          res_r <= res_next_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_BIT) begin
            zero_r  <= (res_next_s == {WIDTH{1'b0}});
            valid_r <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready  = ready_r;
  assign bus.o_valid  = valid_r;
  assign bus.o_diff   = res_r;
  assign bus.o_borrow = br_r;
  assign bus.o_zero   = zero_r;
endmodule

// File: tb/tb_serial_subtractor_v.sv
// Self-checking bench for serial_subtractor_v: directed vector table with a
// result scoreboard, hand-written corner sequences, a WIDTH=1 instance and an
// exhaustive 8-bit sweep spread over parallel instances.
module tb_serial_subtractor_v;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_v_if #(.WIDTH(8)) bus ();
  serial_subtractor_v #(.WIDTH(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

  serial_subtractor_v_if #(.WIDTH(1)) bus1 ();
  serial_subtractor_v #(.WIDTH(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

  // Scoreboard entries are {zero, borrow, diff}.
  logic [9:0]  sb_q[$];
  logic [15:0] lane_done = 16'h0000;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    int         hold;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one operand pair on the 8-bit instance, check latency, result,
  // backpressure stability and the return to IDLE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                       input logic [9:0] exp, input bit intrude);
    int lat;
    int tmo;
    bit bad;
    logic [9:0] got;
    logic [9:0] want;
    tmo = 0;
    while (!bus.o_ready && tmo < 40) begin @(negedge clk); tmo++; end
    check("ready_before_op", 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_ready = 1'b0;
    sb_q.push_back(exp);
    @(negedge clk);
    check("accepted", 32'(bus.o_ready), 32'd0);
    if (intrude) begin
      bus.i_valid = 1'b1; bus.i_a = 8'h11; bus.i_b = 8'h22;
    end else begin
      bus.i_valid = 1'b0; bus.i_a = ~a; bus.i_b = 8'($urandom);
    end
    lat = 0; bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.o_ready) bad = 1'b1;
    end while (!bus.o_valid && lat < 40);
    check("latency", 32'(lat), 32'd8);
    check("ready_low_busy", 32'(bad), 32'd0);
    got  = {bus.o_zero, bus.o_borrow, bus.o_diff};
    want = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
    check($sformatf("result %02h-%02h", a, b), 32'(got), 32'(want));
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.o_valid || {bus.o_zero, bus.o_borrow, bus.o_diff} !== want) bad = 1'b1;
    end
    if (hold > 0) check("backpressure_hold", 32'(bad), 32'd0);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_valid = 1'b0;
    check("idle_after_handshake", 32'({bus.o_valid, bus.o_ready}), 32'b01);
  endtask

  // Exhaustive sweep: lane g covers a in [16g, 16g+15] against every b.
  for (genvar g = 0; g < 16; g++) begin : lane
    serial_subtractor_v_if #(.WIDTH(8)) lbus ();
    logic       lrst_n;
    logic [9:0] lq[$];
    serial_subtractor_v #(.WIDTH(8)) u_dut (.i_clk(clk), .i_rst_n(lrst_n), .bus(lbus.slave));

    initial begin
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] ref_s;
      logic [9:0] want;
      int         tmo;
      lrst_n = 1'b0; lbus.i_valid = 1'b0; lbus.i_ready = 1'b1;
      lbus.i_a = 8'h00; lbus.i_b = 8'h00;
      repeat (2) @(negedge clk);
      lrst_n = 1'b1;
      for (int i = 0; i < 4096; i++) begin
        a = 8'(g * 16 + i / 256);
        b = 8'(i % 256);
        ref_s = {1'b0, a} - {1'b0, b};
        tmo = 0;
        while (!lbus.o_ready && tmo < 40) begin @(negedge clk); tmo++; end
        lbus.i_valid = 1'b1; lbus.i_a = a; lbus.i_b = b;
        lq.push_back({ref_s[7:0] == 8'h00, ref_s[8], ref_s[7:0]});
        @(negedge clk);
        lbus.i_valid = 1'b0;
        tmo = 0;
        while (!lbus.o_valid && tmo < 40) begin @(negedge clk); tmo++; end
        want = lq.pop_front();
        check($sformatf("exh a=%02h b=%02h", a, b),
              32'({lbus.o_zero, lbus.o_borrow, lbus.o_diff}), 32'(want));
      end
      lane_done[g] = 1'b1;
    end
  end

  initial begin
    int         tmo;
    bit         bad;
    logic [1:0] r1;
    vecs[0] = '{a: 8'h05, b: 8'h07, diff: 8'hFE, borrow: 1'b1, zero: 1'b0, hold: 0};
    vecs[1] = '{a: 8'h00, b: 8'h00, diff: 8'h00, borrow: 1'b0, zero: 1'b1, hold: 0};
    vecs[2] = '{a: 8'hFF, b: 8'h01, diff: 8'hFE, borrow: 1'b0, zero: 1'b0, hold: 0};
    vecs[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, zero: 1'b0, hold: 5};
    vecs[4] = '{a: 8'hA5, b: 8'h5A, diff: 8'h4B, borrow: 1'b0, zero: 1'b0, hold: 2};
    vecs[5] = '{a: 8'h01, b: 8'hFF, diff: 8'h02, borrow: 1'b1, zero: 1'b0, hold: 1};

    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_a = 8'h00; bus.i_b = 8'h00;
    bus1.i_valid = 1'b0; bus1.i_ready = 1'b1; bus1.i_a = 1'b0; bus1.i_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", 32'({bus.o_ready, bus.o_valid, bus.o_borrow, bus.o_zero}), 32'b1001);
    check("reset_diff", 32'(bus.o_diff), 32'h00);

    // Release and offer operands right away: the first edge must accept.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].hold,
            {vecs[i].zero, vecs[i].borrow, vecs[i].diff}, 1'b0);

    // Second offer held during RUN and DONE must be ignored.
    do_op(8'h3C, 8'h0F, 0, {1'b0, 1'b0, 8'h2D}, 1'b1);

    // Idle with no offer: state and last result hold.
    repeat (3) @(negedge clk);
    check("idle_hold_flags", 32'({bus.o_ready, bus.o_valid, bus.o_borrow}), 32'b100);
    check("idle_hold_diff", 32'(bus.o_diff), 32'h2D);

    // Reset on the 4th RUN edge aborts the operation.
    bus.i_valid = 1'b1; bus.i_a = 8'h40; bus.i_b = 8'h30;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_flags", 32'({bus.o_ready, bus.o_valid, bus.o_borrow, bus.o_zero}), 32'b1001);
    check("abort_diff", 32'(bus.o_diff), 32'h00);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_valid) bad = 1'b1;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    do_op(8'h40, 8'h30, 0, {1'b0, 1'b0, 8'h10}, 1'b0);

    // WIDTH=1 instance: one RUN edge, all four operand pairs.
    for (int i = 0; i < 4; i++) begin
      r1 = {1'b0, 1'(i >> 1)} - {1'b0, 1'(i)};
      bus1.i_valid = 1'b1; bus1.i_a = 1'(i >> 1); bus1.i_b = 1'(i);
      @(negedge clk);
      bus1.i_valid = 1'b0;
      check("w1_not_yet_valid", 32'(bus1.o_valid), 32'd0);
      @(negedge clk);
      check($sformatf("w1 %0d", i), 32'({bus1.o_valid, bus1.o_zero, bus1.o_borrow, bus1.o_diff}),
            32'({1'b1, ~r1[0], r1[1], r1[0]}));
      @(negedge clk);
    end

    tmo = 0;
    while (lane_done != 16'hFFFF && tmo < 60000) begin @(negedge clk); tmo++; end
    check("exhaustive_done", 32'(lane_done), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
